// File: rtl/spi_boot_master_if.sv
// Request/response and SPI pin bundle for spi_boot_master.
// master: the SPI initiator itself; slave: the requester plus the SPI target pins.
interface spi_boot_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        spi_sck_o;
    logic        spi_csn_o;
    logic        spi_sdo_o;
    logic        spi_sdi_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, spi_sdi_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, spi_sck_o, spi_csn_o, spi_sdo_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, spi_sdi_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, spi_sck_o, spi_csn_o, spi_sdo_o
    );
endinterface

// File: rtl/spi_boot_master.sv
// SPI mode-0 initiator for the PULPino SPI-slave boot port: one 32-bit write (0x02)
// or read (0x0B + dummy cycles) per chip-select frame.
module spi_boot_master #(
    parameter int CLK_DIV      = 4,
    parameter int DUMMY_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_boot_master_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int            CW      = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] HALF    = CW'(CLK_DIV - 1);
    // The accept cycle in IDLE is the last CS-high cycle, so GAP itself is one shorter.
    localparam logic [CW-1:0] GAP_LEN = CW'(2 * CLK_DIV - 2);
    // Nine bits: a read with 255 dummy cycles needs 327 SCK periods.
    localparam logic [8:0]    N_WR    = 9'd72;
    localparam logic [8:0]    N_RD    = 9'(72 + DUMMY_CYCLES);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [8:0]    bit_cnt;
    logic [71:0]   tx;
    logic [31:0]   rx;
    logic          we;
    logic          rise;

    assign bus.req_ready_o = (state == S_IDLE);

    // SCK rises at the end of SETUP and at the end of every low phase that has periods left.
    assign rise = (cnt == '0) &&
                  ((state == S_SETUP) ||
                   (state == S_SHIFT && !bus.spi_sck_o && bit_cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            tx              <= '0;
            rx              <= '0;
            we              <= 1'b0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= '0;
            bus.spi_sck_o   <= 1'b0;
            bus.spi_csn_o   <= 1'b1;
            bus.spi_sdo_o   <= 1'b0;
        end else begin
            bus.rsp_valid_o <= 1'b0;
            if (rise) begin
                state         <= S_SHIFT;
                cnt           <= HALF;
                bus.spi_sck_o <= 1'b1;
                bit_cnt       <= bit_cnt - 9'd1;
                if (bit_cnt <= 9'd32)
                    rx <= {rx[30:0], bus.spi_sdi_i};
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.req_valid_i) begin
                            we            <= bus.req_we_i;
                            tx            <= {bus.req_we_i ? 8'h02 : 8'h0B, bus.req_addr_i,
                                              bus.req_we_i ? bus.req_wdata_i : 32'h0};
                            bit_cnt       <= bus.req_we_i ? N_WR : N_RD;
                            rx            <= '0;
                            cnt           <= HALF;
                            bus.spi_csn_o <= 1'b0;
                            // Both opcodes have a zero MSB.
                            bus.spi_sdo_o <= 1'b0;
                            state         <= S_SETUP;
                        end
                    end
                    S_SETUP: cnt <= cnt - ONE;
                    S_SHIFT: begin
                        if (cnt != '0) begin
                            cnt <= cnt - ONE;
                        end else if (bus.spi_sck_o) begin
                            bus.spi_sck_o <= 1'b0;
                            cnt           <= HALF;
                            tx            <= {tx[70:0], 1'b0};
                            bus.spi_sdo_o <= tx[70];
                        end else begin
                            state <= S_HOLD;
                            cnt   <= HALF;
                        end
                    end
                    S_HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - ONE;
                        end else begin
                            bus.spi_csn_o   <= 1'b1;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_rdata_o <= we ? 32'h0 : rx;
                            cnt             <= GAP_LEN;
                            state           <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (cnt != '0) cnt <= cnt - ONE;
                        else           state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_boot_master.sv
// Bench for spi_boot_master: two instances (CLK_DIV=2/DUMMY=32 and CLK_DIV=1/DUMMY=0)
// with a pin monitor and an SPI-slave read model.
module tb_spi_boot_master;
    localparam int DA = 2, UA = 32, DB = 1, UB = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_boot_master_if ifa();
    spi_boot_master_if ifb();

    spi_boot_master #(.CLK_DIV(DA), .DUMMY_CYCLES(UA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    spi_boot_master #(.CLK_DIV(DB), .DUMMY_CYCLES(UB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic        rq_valid [2];
    logic        rq_we    [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic        sdi_r    [2] = '{1'b0, 1'b0};

    assign ifa.req_valid_i = rq_valid[0];  assign ifb.req_valid_i = rq_valid[1];
    assign ifa.req_we_i    = rq_we[0];     assign ifb.req_we_i    = rq_we[1];
    assign ifa.req_addr_i  = rq_addr[0];   assign ifb.req_addr_i  = rq_addr[1];
    assign ifa.req_wdata_i = rq_wdata[0];  assign ifb.req_wdata_i = rq_wdata[1];
    assign ifa.spi_sdi_i   = sdi_r[0];     assign ifb.spi_sdi_i   = sdi_r[1];

    logic        sck_w [2], csn_w [2], sdo_w [2], rv_w [2], rdy_w [2];
    logic [31:0] rd_w  [2];
    assign sck_w[0] = ifa.spi_sck_o;   assign sck_w[1] = ifb.spi_sck_o;
    assign csn_w[0] = ifa.spi_csn_o;   assign csn_w[1] = ifb.spi_csn_o;
    assign sdo_w[0] = ifa.spi_sdo_o;   assign sdo_w[1] = ifb.spi_sdo_o;
    assign rv_w[0]  = ifa.rsp_valid_o; assign rv_w[1]  = ifb.rsp_valid_o;
    assign rdy_w[0] = ifa.req_ready_o; assign rdy_w[1] = ifb.req_ready_o;
    assign rd_w[0]  = ifa.rsp_rdata_o; assign rd_w[1]  = ifb.rsp_rdata_o;

    // Slave model inputs, set by the stimulus before each frame.
    int          exp_n      [2] = '{72, 72};
    logic [31:0] slave_word [2] = '{32'h0, 32'h0};

    // Pin monitor, sampled on the falling clk edge.
    int          rises [2] = '{0, 0};
    int          falls [2] = '{0, 0};
    int          cs_low [2] = '{0, 0};
    int          high_run [2] = '{0, 0};
    int          last_gap [2] = '{0, 0};
    int          toggles [2] = '{0, 0};
    int          rsp_cnt [2] = '{0, 0};
    int          frames [2] = '{0, 0};
    logic [511:0] mosi [2] = '{default: '0};
    logic [31:0] rsp_data [2] = '{32'h0, 32'h0};
    logic        rsp_edge_ok [2] = '{1'b0, 1'b0};
    logic        prev_sck [2] = '{1'b0, 1'b0};
    logic        prev_csn [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int k;
            if (!csn_w[d] && prev_csn[d]) begin
                last_gap[d] = high_run[d]; high_run[d] = 0; cs_low[d] = 1;
                rises[d] = 0; falls[d] = 0; toggles[d] = 0; mosi[d] = '0; frames[d]++;
            end else if (!csn_w[d]) cs_low[d]++;
            else high_run[d]++;
            if (sck_w[d] && !prev_sck[d]) begin
                rises[d]++;
                mosi[d] = {mosi[d][510:0], sdo_w[d]};
            end
            if (!sck_w[d] && prev_sck[d]) falls[d]++;
            if (sck_w[d] != prev_sck[d] && !csn_w[d]) toggles[d]++;
            if (rv_w[d]) begin
                rsp_cnt[d]++;
                rsp_data[d]    = rd_w[d];
                rsp_edge_ok[d] = csn_w[d] && !prev_csn[d];
            end
            // Slave shifts its word out MSB first, one bit per falling SCK edge, over the last 32 periods.
            k = falls[d] - (exp_n[d] - 32);
            sdi_r[d] = (k >= 0 && k < 32) ? slave_word[d][31 - k] : 1'b0;
            prev_sck[d] = sck_w[d];
            prev_csn[d] = csn_w[d];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold);
        bit acc = 0;
        rq_valid[d] = 1'b1; rq_we[d] = we; rq_addr[d] = addr; rq_wdata[d] = wd;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            if (rdy_w[d]) begin
                @(posedge clk); #1;
                acc = 1;
            end
        end
        if (!hold) rq_valid[d] = 1'b0;
        if (!acc) timeout("accept");
        else      chk("csn_low_after_accept", csn_w[d], 0);
    endtask

    task automatic wait_rsp(input int d);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (rv_w[d]) seen = 1;
        end
        if (!seen) timeout("rsp_valid");
    endtask

    // Reference: frame shape derived from opcode/addr/data layout and clock division.
    task automatic check_frame(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] sw,
                               input int div, input int dum);
        int n = we ? 72 : 72 + dum;
        logic [511:0] e;
        if (we) e = {440'b0, 8'h02, addr, wd};
        else    e = {472'b0, 8'h0B, addr} << (dum + 32);
        chk("sck_periods", rises[d], n);
        chk("mosi_stream", mosi[d], e);
        chk("cs_low_cycles", cs_low[d], 2 * div + 2 * div * n);
        chk("rsp_rdata", rsp_data[d], we ? 32'h0 : sw);
        chk("rsp_with_cs_rise", rsp_edge_ok[d], 1);
    endtask

    initial begin
        int c0, f0, lowc;
        logic we;
        logic [31:0] a, w, s, r1;
        bit acc;
        for (int d = 0; d < 2; d++) begin
            rq_valid[d] = 0; rq_we[d] = 0; rq_addr[d] = 0; rq_wdata[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy_w[0], 1);
        chk("rst_rsp_valid", rv_w[0], 0);
        chk("rst_rdata", rd_w[0], 0);
        chk("rst_sck", sck_w[0], 0);
        chk("rst_csn", csn_w[0], 1);
        chk("rst_sdo", sdo_w[0], 0);
        chk("rst_ready_b", rdy_w[1], 1);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Fixed write
        exp_n[0] = 72; c0 = rsp_cnt[0];
        do_req(0, 1'b1, 32'h1A10_7008, 32'h0000_0000, 0);
        wait_rsp(0); @(posedge clk); #1;
        check_frame(0, 1'b1, 32'h1A10_7008, 32'h0, 32'h0, DA, UA);
        repeat (20) @(posedge clk); #1;
        chk("wr_rsp_once", rsp_cnt[0] - c0, 1);

        // Fixed read
        exp_n[0] = 72 + UA; slave_word[0] = 32'hDEAD_BEEF; c0 = rsp_cnt[0];
        do_req(0, 1'b0, 32'h0010_0000, 32'h1234_5678, 0);
        wait_rsp(0); @(posedge clk); #1;
        check_frame(0, 1'b0, 32'h0010_0000, 32'h0, 32'hDEAD_BEEF, DA, UA);
        repeat (20) @(posedge clk); #1;
        chk("rd_rsp_once", rsp_cnt[0] - c0, 1);
        chk("rd_rdata_held", rd_w[0], 32'hDEAD_BEEF);

        // Random mix
        for (int t = 0; t < 6; t++) begin
            we = 1'($urandom_range(0, 1)); a = $urandom; w = $urandom; s = $urandom;
            exp_n[0] = we ? 72 : 72 + UA; slave_word[0] = s;
            do_req(0, we, a, w, 0);
            wait_rsp(0); @(posedge clk); #1;
            check_frame(0, we, a, w, s, DA, UA);
            repeat (5) @(posedge clk);
        end

        // Back-to-back write then read with valid held
        repeat (10) @(posedge clk); #1;
        exp_n[0] = 72; f0 = frames[0]; c0 = rsp_cnt[0];
        do_req(0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1);
        a = $urandom; s = $urandom;
        rq_we[0] = 1'b0; rq_addr[0] = a; exp_n[0] = 72 + UA; slave_word[0] = s;
        lowc = 0; acc = 0; r1 = 32'hFFFF_FFFF;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            if (rv_w[0]) r1 = rd_w[0];
            if (rdy_w[0]) acc = 1;
            else          lowc++;
        end
        @(posedge clk); #1;
        rq_valid[0] = 1'b0;
        if (!acc) timeout("b2b_second_accept");
        chk("b2b_ready_low_cycles", lowc, 2 * DA + 2 * DA * 72 + 2 * DA - 1);
        chk("b2b_first_rdata", r1, 0);
        wait_rsp(0); @(posedge clk); #1;
        check_frame(0, 1'b0, a, 32'h0, s, DA, UA);
        chk("b2b_cs_high_gap", last_gap[0], 2 * DA);
        repeat (60) @(posedge clk); #1;
        chk("b2b_frames", frames[0] - f0, 2);
        chk("b2b_rsps", rsp_cnt[0] - c0, 2);

        // CLK_DIV=1, no dummy cycles, on the second instance
        s = $urandom; a = $urandom;
        exp_n[1] = 72; slave_word[1] = s;
        do_req(1, 1'b0, a, 32'h0, 0);
        wait_rsp(1); @(posedge clk); #1;
        check_frame(1, 1'b0, a, 32'h0, s, DB, UB);
        chk("div1_sck_toggles", toggles[1], 144);

        // Reset mid-frame at SCK period 40 of a write
        exp_n[0] = 72;
        do_req(0, 1'b1, 32'h5555_0000, 32'hA5A5_A5A5, 0);
        acc = 0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(posedge clk);
            if (rises[0] >= 40) acc = 1;
        end
        if (!acc) timeout("reach_period_40");
        #3; rst_n = 1'b0; #1;
        chk("midrst_csn", csn_w[0], 1);
        chk("midrst_sck", sck_w[0], 0);
        chk("midrst_sdo", sdo_w[0], 0);
        chk("midrst_ready", rdy_w[0], 1);
        chk("midrst_rsp_valid", rv_w[0], 0);
        c0 = rsp_cnt[0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk); #1;
        chk("midrst_no_rsp", rsp_cnt[0] - c0, 0);
        w = $urandom; a = $urandom;
        do_req(0, 1'b1, a, w, 0);
        wait_rsp(0); @(posedge clk); #1;
        check_frame(0, 1'b1, a, w, 32'h0, DA, UA);

        // Request pulsed only during GAP must be ignored
        repeat (10) @(posedge clk); #1;
        do_req(0, 1'b1, 32'h0000_0040, 32'h1111_2222, 0);
        wait_rsp(0);
        f0 = frames[0];
        rq_valid[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = 32'h0BAD_0000;
        chk("gap_ready_low", rdy_w[0], 0);
        @(posedge clk); #1;
        c0 = rsp_cnt[0];
        rq_valid[0] = 1'b0;
        repeat (100) @(posedge clk); #1;
        chk("gap_no_frame", frames[0] - f0, 0);
        chk("gap_no_rsp", rsp_cnt[0] - c0, 0);
        chk("gap_csn_idle", csn_w[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
